// File: rtl/fpio_fifo_out_server.sv
// -----------------------------------------------------------------------------
// fpio_fifo_out_server
//
// FIFO that serves the fpio FIFO-out client port. Words arrive from an
// fpio_fifo_out_client over a data_en/data_ack request-acknowledge handshake
// and are presented first-word-fall-through on a valid/ready port to the
// downstream consumer (transport or pin-serializer stage).
//
// Parameters:
//   FIFO_BITS  - width of the avail free-space report (DEPTH <= 2**FIFO_BITS-1)
//   DATA_WIDTH - width of a data word
//   DEPTH      - storage entries, power of two, minimum 2
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous, active-high reset
//   data     in   client write data, valid while data_en=1
//   data_en  in   client write request, held until acknowledged
//   data_ack out  one-cycle acknowledge that data was captured
//   avail    out  free entries (DEPTH - count), zero-extended
//   rd_data  out  head-of-FIFO word (combinational, FWFT)
//   rd_valid out  FIFO not empty
//   rd_ready in   consumer accepts rd_data when rd_valid=1
//   level    out  current occupancy
//   hwm      out  high-water mark of occupancy
//
// Optional feature macro: FPIO_FIFO_OUT_SERVER_HWM_EN
//   defined   - hwm is a sticky register tracking peak occupancy
//   undefined - hwm is tied to zero
// -----------------------------------------------------------------------------
module fpio_fifo_out_server #(
    parameter int FIFO_BITS  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic                         data_en,
    output logic                         data_ack,
    output logic [FIFO_BITS-1:0]         avail,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [$clog2(DEPTH):0]       level,
    output logic [$clog2(DEPTH):0]       hwm
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  wr_fire;
    logic                  rd_fire;

    // A capture is blocked while ack_q is high so the request the client is
    // still holding during the acknowledge cycle is not stored twice. Fullness
    // is judged on the registered count, so a same-edge read never frees space
    // for a capture in that same edge.
    assign wr_fire = data_en && !ack_q && (cnt_q != CW'(DEPTH));
    assign rd_fire = rd_ready && (cnt_q != '0);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ack_d  = wr_fire;
        // DEPTH is a power of two, so natural pointer overflow is modulo DEPTH.
        if (wr_fire) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_fire) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({wr_fire, rd_fire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ack_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ack_q  <= ack_d;
        end
    end

    // Storage carries no reset; its contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wptr_q] <= data;
        end
    end

    assign data_ack = ack_q;
    assign rd_valid = (cnt_q != '0);
    assign rd_data  = mem_q[rptr_q];
    assign level    = cnt_q;
    assign avail    = FIFO_BITS'(DEPTH) - FIFO_BITS'(cnt_q);

`ifdef FPIO_FIFO_OUT_SERVER_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    // Occupancy never exceeds DEPTH, so the mark saturates there on its own.
    always_comb begin
        hwm_d = hwm_q;
        if (cnt_d > hwm_q) begin
            hwm_d = cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

endmodule
